// File: rtl/seq_mul.sv
// Multi-cycle shift-add multiplier: one multiplier bit per clock, valid/ready on both sides.
// Optional two's-complement operands are handled by sign-magnitude conversion around an unsigned core.
module seq_mul #(
  parameter int SIZE_   = 8,
  parameter int SIGNED_ = 0
) (
  input  logic               clk_,
  input  logic               rst_,
  input  logic [SIZE_-1:0]   x_,
  input  logic [SIZE_-1:0]   y_,
  input  logic               in_valid_,
  output logic               in_ready_,
  output logic [2*SIZE_-1:0] p_,
  output logic [SIZE_-1:0]   z_,
  output logic               ovf_,
  output logic               out_valid_,
  input  logic               out_ready_,
  output logic               busy_
);

  localparam int CNT_W = $clog2(SIZE_);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE_ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*SIZE_-1:0]   r_mcand;
  logic [SIZE_-1:0]     r_mplier;
  logic [2*SIZE_-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic [2*SIZE_-1:0]   r_p;
  logic [SIZE_-1:0]     r_z;
  logic                 r_ovf;

  logic                 w_accept;
  logic                 w_last;
  logic [SIZE_-1:0]     w_x_mag;
  logic [SIZE_-1:0]     w_y_mag;
  logic                 w_neg;
  logic [2*SIZE_-1:0]   w_acc_nxt;
  logic [2*SIZE_-1:0]   w_prod;
  logic                 w_ovf;

  assign w_accept = (r_state == S_IDLE) && in_valid_;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_)  w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready_) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Magnitude of the most negative value wraps to itself, which read unsigned is the exact magnitude.
  always_comb begin
    w_x_mag = x_;
    w_y_mag = y_;
    w_neg   = 1'b0;
    if (SIGNED_ != 0) begin
      if (x_[SIZE_-1]) w_x_mag = '0 - x_;
      if (y_[SIZE_-1]) w_y_mag = '0 - y_;
      w_neg = x_[SIZE_-1] ^ y_[SIZE_-1];
    end
  end

  always_comb begin
    w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_prod    = r_neg ? ('0 - w_acc_nxt) : w_acc_nxt;
    if (SIGNED_ != 0)
      w_ovf = !((&w_prod[2*SIZE_-1:SIZE_-1]) || !(|w_prod[2*SIZE_-1:SIZE_-1]));
    else
      w_ovf = |w_prod[2*SIZE_-1:SIZE_];
  end

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_p      <= '0;
      r_z      <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{SIZE_{1'b0}}, w_x_mag};
      r_mplier <= w_y_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= w_neg;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_p   <= w_prod;
        r_z   <= w_prod[SIZE_-1:0];
        r_ovf <= w_ovf;
      end
    end
  end

  assign in_ready_  = (r_state == S_IDLE);
  assign out_valid_ = (r_state == S_DONE);
  assign busy_      = (r_state == S_RUN);
  assign p_         = r_p;
  assign z_         = r_z;
  assign ovf_       = r_ovf;

endmodule

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul: unsigned 8-bit, signed 8-bit and unsigned 16-bit instances.
module tb_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0]  ux, uy, uz;
  logic [15:0] up;
  logic        uiv, uir, uovf, uov, uor, ubusy;

  logic [7:0]  sx, sy, sz;
  logic [15:0] sp;
  logic        siv, sir, sovf, sov, sor, sbusy;

  logic [15:0] wx, wy, wz;
  logic [31:0] wp;
  logic        wiv, wir, wovf, wov, wor_, wbusy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul #(.SIZE_(8), .SIGNED_(0)) u_u8 (
    .clk_(clk), .rst_(rst), .x_(ux), .y_(uy), .in_valid_(uiv), .in_ready_(uir),
    .p_(up), .z_(uz), .ovf_(uovf), .out_valid_(uov), .out_ready_(uor), .busy_(ubusy)
  );

  seq_mul #(.SIZE_(8), .SIGNED_(1)) u_s8 (
    .clk_(clk), .rst_(rst), .x_(sx), .y_(sy), .in_valid_(siv), .in_ready_(sir),
    .p_(sp), .z_(sz), .ovf_(sovf), .out_valid_(sov), .out_ready_(sor), .busy_(sbusy)
  );

  seq_mul #(.SIZE_(16), .SIGNED_(0)) u_u16 (
    .clk_(clk), .rst_(rst), .x_(wx), .y_(wy), .in_valid_(wiv), .in_ready_(wir),
    .p_(wp), .z_(wz), .ovf_(wovf), .out_valid_(wov), .out_ready_(wor_), .busy_(wbusy)
  );

  // Drivers: accept one pair, scramble the operand inputs, return latency and busy-cycle count.
  task automatic u8_txn(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
    ux = a; uy = b; uiv = 1'b1;
    @(posedge clk); #1;
    uiv = 1'b0; ux = ~a; uy = ~b;
    lat = 0; bcnt = 0;
    while (!uov && lat < 40) begin
      bcnt += int'(ubusy);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic s8_txn(input logic [7:0] a, input logic [7:0] b, output int lat);
    sx = a; sy = b; siv = 1'b1;
    @(posedge clk); #1;
    siv = 1'b0; sx = ~a; sy = ~b;
    lat = 0;
    while (!sov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    n_checks++; if (up !== 16'h0)  begin n_fail++; $display("FAIL reset_p got %h want 0000", up); end
    n_checks++; if (uz !== 8'h0)   begin n_fail++; $display("FAIL reset_z got %h want 00", uz); end
    n_checks++; if (uovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", uovf); end
    n_checks++; if (uov !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", uov); end
    n_checks++; if (ubusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", ubusy); end
    n_checks++; if (uir !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", uir); end
    n_checks++; if (sir !== 1'b1)  begin n_fail++; $display("FAIL reset_s8_in_ready got %b want 1", sir); end
    n_checks++; if (wp !== 32'h0)  begin n_fail++; $display("FAIL reset_u16_p got %h want 0", wp); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsigned_regression;
    int lat, bc;
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        u8_txn(8'(a), 8'(b), lat, bc);
        n_checks++; if (up !== 16'(a * b)) begin n_fail++; $display("FAIL u8_prod %0d*%0d got %0d want %0d", a, b, up, a * b); end
        n_checks++; if (uovf !== 1'b0) begin n_fail++; $display("FAIL u8_ovf %0d*%0d got %b want 0", a, b, uovf); end
        n_checks++; if (lat != 8) begin n_fail++; $display("FAIL u8_latency %0d*%0d got %0d want 8", a, b, lat); end
        n_checks++; if (bc != 8) begin n_fail++; $display("FAIL u8_busy_cycles %0d*%0d got %0d want 8", a, b, bc); end
        @(posedge clk); #1;
        n_checks++; if (uir !== 1'b1) begin n_fail++; $display("FAIL u8_idle_after_done got %b want 1", uir); end
      end
    end
  endtask

  task automatic test_unsigned_edges;
    int lat, bc;
    u8_txn(8'd255, 8'd255, lat, bc);
    n_checks++; if (up !== 16'hFE01) begin n_fail++; $display("FAIL u8_255sq_p got %h want FE01", up); end
    n_checks++; if (uz !== 8'h01)    begin n_fail++; $display("FAIL u8_255sq_z got %h want 01", uz); end
    n_checks++; if (uovf !== 1'b1)   begin n_fail++; $display("FAIL u8_255sq_ovf got %b want 1", uovf); end
    @(posedge clk); #1;
    u8_txn(8'd15, 8'd17, lat, bc);
    n_checks++; if (up !== 16'h00FF) begin n_fail++; $display("FAIL u8_15x17_p got %h want 00FF", up); end
    n_checks++; if (uz !== 8'hFF)    begin n_fail++; $display("FAIL u8_15x17_z got %h want FF", uz); end
    n_checks++; if (uovf !== 1'b0)   begin n_fail++; $display("FAIL u8_15x17_ovf got %b want 0", uovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    int lat;
    s8_txn(8'hFD, 8'h05, lat);
    n_checks++; if (sp !== 16'hFFF1) begin n_fail++; $display("FAIL s8_m3x5_p got %h want FFF1", sp); end
    n_checks++; if (sz !== 8'hF1)    begin n_fail++; $display("FAIL s8_m3x5_z got %h want F1", sz); end
    n_checks++; if (sovf !== 1'b0)   begin n_fail++; $display("FAIL s8_m3x5_ovf got %b want 0", sovf); end
    n_checks++; if (lat != 8)        begin n_fail++; $display("FAIL s8_latency got %0d want 8", lat); end
    @(posedge clk); #1;
    s8_txn(8'h80, 8'h80, lat);
    n_checks++; if (sp !== 16'h4000) begin n_fail++; $display("FAIL s8_m128sq_p got %h want 4000", sp); end
    n_checks++; if (sovf !== 1'b1)   begin n_fail++; $display("FAIL s8_m128sq_ovf got %b want 1", sovf); end
    @(posedge clk); #1;
    s8_txn(8'h80, 8'h01, lat);
    n_checks++; if (sp !== 16'hFF80) begin n_fail++; $display("FAIL s8_m128x1_p got %h want FF80", sp); end
    n_checks++; if (sovf !== 1'b0)   begin n_fail++; $display("FAIL s8_m128x1_ovf got %b want 0", sovf); end
    @(posedge clk); #1;
    s8_txn(8'h0C, 8'hF6, lat);
    n_checks++; if (sp !== 16'hFF88) begin n_fail++; $display("FAIL s8_12xm10_p got %h want FF88", sp); end
    n_checks++; if (sovf !== 1'b0)   begin n_fail++; $display("FAIL s8_12xm10_ovf got %b want 0", sovf); end
    @(posedge clk); #1;
    s8_txn(8'h10, 8'h08, lat);
    n_checks++; if (sp !== 16'h0080) begin n_fail++; $display("FAIL s8_16x8_p got %h want 0080", sp); end
    n_checks++; if (sovf !== 1'b1)   begin n_fail++; $display("FAIL s8_16x8_ovf got %b want 1", sovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int first, second, nres;
    first = -1; second = -1; nres = 0;
    ux = 8'd5; uy = 8'd7; uiv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (uov) begin
        nres++;
        if (first < 0) first = i; else if (second < 0) second = i;
        n_checks++; if (up !== 16'd35) begin n_fail++; $display("FAIL b2b_p got %0d want 35", up); end
      end
    end
    uiv = 1'b0;
    n_checks++; if (nres != 2)  begin n_fail++; $display("FAIL b2b_results got %0d want 2", nres); end
    n_checks++; if (first != 8) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 8", first); end
    n_checks++; if (second - first != 10) begin n_fail++; $display("FAIL b2b_period got %0d want 10", second - first); end
  endtask

  task automatic test_backpressure;
    int lat, bc;
    uor = 1'b0;
    u8_txn(8'd12, 8'd11, lat, bc);
    n_checks++; if (up !== 16'd132) begin n_fail++; $display("FAIL bp_p got %0d want 132", up); end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin ux = 8'd200; uy = 8'd200; uiv = 1'b1; end
      @(posedge clk); #1;
      uiv = 1'b0;
      n_checks++; if (up !== 16'd132)  begin n_fail++; $display("FAIL bp_hold_p cyc %0d got %0d want 132", i, up); end
      n_checks++; if (uz !== 8'd132)   begin n_fail++; $display("FAIL bp_hold_z cyc %0d got %0d want 132", i, uz); end
      n_checks++; if (uovf !== 1'b0)   begin n_fail++; $display("FAIL bp_hold_ovf cyc %0d got %b want 0", i, uovf); end
      n_checks++; if (uov !== 1'b1)    begin n_fail++; $display("FAIL bp_hold_out_valid cyc %0d got %b want 1", i, uov); end
      n_checks++; if (uir !== 1'b0)    begin n_fail++; $display("FAIL bp_hold_in_ready cyc %0d got %b want 0", i, uir); end
    end
    uor = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (uov !== 1'b0)   begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", uov); end
    n_checks++; if (uir !== 1'b1)   begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", uir); end
    n_checks++; if (ubusy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_pulse_busy got %b want 0", ubusy); end
    u8_txn(8'd3, 8'd4, lat, bc);
    n_checks++; if (up !== 16'd12) begin n_fail++; $display("FAIL bp_next_p got %0d want 12", up); end
    @(posedge clk); #1;
  endtask

  task automatic test_midrun_reset;
    int lat, bc, seen;
    ux = 8'd7; uy = 8'd9; uiv = 1'b1;
    @(posedge clk); #1;
    uiv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ubusy !== 1'b1) begin n_fail++; $display("FAIL mr_busy_before got %b want 1", ubusy); end
    rst = 1'b1;
    #1;
    n_checks++; if (up !== 16'h0)   begin n_fail++; $display("FAIL mr_p got %h want 0000", up); end
    n_checks++; if (uz !== 8'h0)    begin n_fail++; $display("FAIL mr_z got %h want 00", uz); end
    n_checks++; if (uovf !== 1'b0)  begin n_fail++; $display("FAIL mr_ovf got %b want 0", uovf); end
    n_checks++; if (ubusy !== 1'b0) begin n_fail++; $display("FAIL mr_busy got %b want 0", ubusy); end
    n_checks++; if (uir !== 1'b1)   begin n_fail++; $display("FAIL mr_in_ready got %b want 1", uir); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen += int'(uov);
    end
    n_checks++; if (seen != 0)    begin n_fail++; $display("FAIL mr_stale_out_valid got %0d want 0", seen); end
    n_checks++; if (uir !== 1'b1) begin n_fail++; $display("FAIL mr_in_ready_after got %b want 1", uir); end
    u8_txn(8'd6, 8'd6, lat, bc);
    n_checks++; if (up !== 16'd36) begin n_fail++; $display("FAIL mr_next_p got %0d want 36", up); end
    n_checks++; if (lat != 8)      begin n_fail++; $display("FAIL mr_next_latency got %0d want 8", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_wide;
    int lat;
    wx = 16'hFFFF; wy = 16'd2; wiv = 1'b1;
    @(posedge clk); #1;
    wiv = 1'b0; wx = 16'h0; wy = 16'h0;
    lat = 0;
    while (!wov && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (wp !== 32'h0001FFFE) begin n_fail++; $display("FAIL u16_p got %h want 0001FFFE", wp); end
    n_checks++; if (wz !== 16'hFFFE)     begin n_fail++; $display("FAIL u16_z got %h want FFFE", wz); end
    n_checks++; if (wovf !== 1'b1)       begin n_fail++; $display("FAIL u16_ovf got %b want 1", wovf); end
    n_checks++; if (lat != 16)           begin n_fail++; $display("FAIL u16_latency got %0d want 16", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    ux = '0; uy = '0; uiv = 1'b0; uor = 1'b1;
    sx = '0; sy = '0; siv = 1'b0; sor = 1'b1;
    wx = '0; wy = '0; wiv = 1'b0; wor_ = 1'b1;
    #12;
    test_reset;
    test_unsigned_regression;
    test_unsigned_edges;
    test_signed;
    test_back_to_back;
    test_backpressure;
    test_midrun_reset;
    test_wide;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised multi-cycle shift-add multiplier, the sequential successor to the combinational `mul` block. It accepts one operand pair per transaction over a valid/ready handshake and computes one multiplier bit per clock. It returns the full double-width product, the truncated `SIZE_`-bit product and an overflow flag. It supports unsigned or two's-complement operands by parameter and is the multiply engine for the iterative factorial datapath.

## Interface
- `SIZE_`, default 8: operand width in bits; must be ≥ 2.
- `SIGNED_`, default 0: 0 treats operands as unsigned, 1 as two's complement.
- `clk_`  in  1  clock; all state changes on the rising edge.
- `rst_`  in  1  reset; asynchronous and active-high.
- `x_`  in  SIZE_  multiplicand; sampled only at acceptance.
- `y_`  in  SIZE_  multiplier; sampled only at acceptance.
- `in_valid_`  in  1  operand pair present.
- `in_ready_`  out  1  block can accept; high only in IDLE.
- `p_`  out  2*SIZE_  full product.
- `z_`  out  SIZE_  low `SIZE_` bits of `p_`.
- `ovf_`  out  1  product not representable in `SIZE_` bits.
- `out_valid_`  out  1  result valid; high only in DONE.
- `out_ready_`  in  1  consumer takes result.
- `busy_`  out  1  high in RUN.

## Operation
- State IDLE:
  - `in_ready_`=1.
  - On `in_valid_`&&`in_ready_`:
    - Latch operand magnitudes: absolute values if `SIGNED_`=1, raw otherwise.
    - Latch result sign = `x_`[MSB]^`y_`[MSB] (signed mode only).
    - Clear accumulator; set bit counter to 0; go to RUN.
- State RUN:
  - Each cycle, if the current multiplier LSB is 1, add the shifted multiplicand into the 2*SIZE_-bit accumulator.
  - Shift the multiplier right and the multiplicand left; increment the counter.
  - After the edge that processes bit `SIZE_`-1, go to DONE.
  - On that same edge, register `p_`: the accumulator result, two's-complement negated if the sign flag is set.
  - Register `z_` and `ovf_` on that edge as well.
- `ovf_` rules:
  - Unsigned: `ovf_`=1 iff `p_`[2*SIZE_-1:SIZE_]≠0.
  - Signed: `ovf_`=1 iff `p_`[2*SIZE_-1:SIZE_-1] is not all-zeros or all-ones.
- Signed magnitude of -2^(SIZE_-1) is 2^(SIZE_-1) held in SIZE_ bits unsigned; no loss.
- State DONE:
  - `out_valid_`=1.
  - `p_`/`z_`/`ovf_` are held stable until `out_valid_`&&`out_ready_`, then go to IDLE.
- `in_valid_` outside IDLE is ignored; no queueing.
- `x_`/`y_` changes after acceptance do not affect the result.
- Zero operand still takes the full `SIZE_` cycles; there is no early exit.

## Timing
- Acceptance edge E0. RUN occupies edges E1..E`SIZE_`. `out_valid_` rises after edge E`SIZE_`, i.e. latency `SIZE_` cycles.
- `busy_` is high for exactly `SIZE_` cycles.
- With `out_ready_` held high: DONE lasts 1 cycle, and `in_ready_` returns high after edge E`SIZE_`+1. Back-to-back throughput is one result per `SIZE_`+2 cycles.
- `in_ready_`, `out_valid_` and `busy_` are decoded from registered state; none depend combinationally on inputs.
- Reset values:
  - State IDLE.
  - `p_`=0, `z_`=0, `ovf_`=0.
  - `out_valid_`=0, `busy_`=0, `in_ready_`=1.
- Reset mid-RUN or mid-DONE:
  - Outputs go to reset values immediately, asynchronously.
  - The pending result is discarded; no `out_valid_` follows.
- `out_ready_` high while not in DONE has no effect.

## Test plan
- Unsigned `SIZE_`=8 regression, x,y in 0..9: send each pair → `p_`=x*y, `ovf_`=0 for all, `out_valid_` exactly 8 cycles after each acceptance.
- Unsigned 255×255 → `p_`=16'hFE01, `z_`=8'h01, `ovf_`=1. Then 15×17 → `p_`=255, `ovf_`=0.
- `SIGNED_`=1, `SIZE_`=8:
  - -3×5 → `p_`=16'hFFF1, `z_`=8'hF1, `ovf_`=0.
  - -128×-128 → `p_`=16'h4000, `ovf_`=1.
  - -128×1 → `p_`=16'hFF80, `ovf_`=0.
- Backpressure: hold `out_ready_`=0 for 5 cycles after `out_valid_` → `p_`/`z_`/`ovf_` stable, `in_ready_`=0. A new `in_valid_` pulse during that window is ignored. Releasing `out_ready_` returns to IDLE next edge.
- Mid-run reset: accept 7×9, assert `rst_` 3 cycles later for 2 cycles → outputs zero immediately, `in_ready_`=1 after release. Next transaction 6×6 → `p_`=36 with normal latency.
- `SIZE_`=16 unsigned: 65535×2 → `p_`=32'h0001FFFE, `ovf_`=1, latency 16 cycles.
